in_seq_gen: RTL and testbench

- Upstream stimulus stage for the 3-input / 2-output `in_out` block.
- Plays a loadable table of up to 8 three-bit patterns onto its `in_1`/`in_2`/`in_3` outputs, which drive the `in_out` inputs directly.
- Each pattern is held for a fixed number of clock cycles.
- Controlled by a start/busy/done handshake, so a hand-written delay-based stimulus is replaced by a synthesizable, cycle-exact sequencer.

---
 rtl/in_seq_gen_if.sv | 26 ++
 rtl/in_seq_gen.sv | 113 +++++++++++
 tb/tb_in_seq_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/in_seq_gen_if.sv
// Handshake, table-write and pattern-output bundle for in_seq_gen.
// master drives start/table writes and observes the playback; slave is the sequencer.
interface in_seq_gen_if;
  logic       start;
  logic [2:0] num_steps;
  logic       loop;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       in_1;
  logic       in_2;
  logic       in_3;
  logic       busy;
  logic       done;
  logic [2:0] step;

  modport master (
    output start, num_steps, loop, wr_en, wr_addr, wr_data,
    input  in_1, in_2, in_3, busy, done, step
  );

  modport slave (
    input  start, num_steps, loop, wr_en, wr_addr, wr_data,
    output in_1, in_2, in_3, busy, done, step
  );
endinterface

// File: rtl/in_seq_gen.sv
// Cycle-exact pattern sequencer: plays table entries 0..num_steps, each held HOLD_CYCLES clocks.
// Optional macro SEQ_LOOP_EN: with loop=1 at end of a pass, restart from entry 0 without a gap.
module in_seq_gen #(
  parameter int HOLD_CYCLES = 100,
  parameter int DEPTH       = 8
) (
  input logic         clk,
  input logic         rst,
  in_seq_gen_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [2:0]       pat_q, pat_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifndef SEQ_LOOP_EN
  logic unused_loop;
  assign unused_loop = bus.loop;
`endif

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    pat_d   = pat_q;
    step_d  = step_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous table write
        if (bus.start) begin
          pat_d   = mem_q[0];
          step_d  = 3'd0;
          last_d  = bus.num_steps;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (bus.wr_en) begin
          mem_d[bus.wr_addr] = bus.wr_data;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (step_q != last_q) begin
          step_d = step_q + 3'd1;
          pat_d  = mem_q[step_q + 3'd1];
          cnt_d  = CNT_LOAD;
        end else begin
          done_d = 1'b1;
`ifdef SEQ_LOOP_EN
          if (bus.loop) begin
            step_d = 3'd0;
            pat_d  = mem_q[0];
            cnt_d  = CNT_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'b000;
      pat_q   <= 3'b000;
      step_q  <= 3'd0;
      last_q  <= 3'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_1 = pat_q[2];
  assign bus.in_2 = pat_q[1];
  assign bus.in_3 = pat_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_in_seq_gen.sv
// Bench for in_seq_gen: two instances (HOLD_CYCLES=4 and 1) share one stimulus stream,
// each checked every cycle against a time-since-start reference model.
module tb_in_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, loop, wr_en;
  logic [2:0] num_steps, wr_addr, wr_data;

  always #5 clk = ~clk;

  in_seq_gen_if if_a ();
  in_seq_gen_if if_b ();

  assign if_a.start = start;     assign if_b.start = start;
  assign if_a.num_steps = num_steps; assign if_b.num_steps = num_steps;
  assign if_a.loop = loop;       assign if_b.loop = loop;
  assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;

  in_seq_gen #(.HOLD_CYCLES(4), .DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  in_seq_gen #(.HOLD_CYCLES(1), .DEPTH(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // {pattern[7:5], busy[4], done[3], step[2:0]}
  logic [7:0] obs [2];
  assign obs[0] = {if_a.in_1, if_a.in_2, if_a.in_3, if_a.busy, if_a.done, if_a.step};
  assign obs[1] = {if_b.in_1, if_b.in_2, if_b.in_3, if_b.busy, if_b.done, if_b.step};

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: position in the sequence is just the number of edges since start
  logic [2:0] m_mem [2][8];
  bit         m_run  [2];
  bit         m_done [2];
  int         m_t    [2];
  logic [2:0] m_last [2];
  logic [2:0] m_pat  [2];
  logic [2:0] m_step [2];

  function automatic int hold_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit loop_on();
`ifdef SEQ_LOOP_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int h;
      h = hold_of(i);
      if (rst) begin
        for (int a = 0; a < 8; a++) m_mem[i][a] = 3'b000;
        m_run[i] = 0; m_done[i] = 0; m_t[i] = 0;
        m_last[i] = 3'd0; m_pat[i] = 3'b000; m_step[i] = 3'd0;
      end else begin
        m_done[i] = 0;
        if (!m_run[i]) begin
          if (start) begin
            m_run[i]  = 1;
            m_t[i]    = 0;
            m_last[i] = num_steps;
            m_step[i] = 3'd0;
            m_pat[i]  = m_mem[i][0];
          end else if (wr_en) begin
            m_mem[i][wr_addr] = wr_data;
          end
        end else begin
          if (m_t[i] + 1 == (int'(m_last[i]) + 1) * h) begin
            m_done[i] = 1;
            if (loop_on()) m_t[i] = 0;
            else           m_run[i] = 0;
          end else begin
            m_t[i] = m_t[i] + 1;
          end
          m_step[i] = 3'(m_t[i] / h);
          m_pat[i]  = m_mem[i][m_step[i]];
        end
      end
    end
  endtask

  task automatic check(input string tag);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      assert (obs[i][7:5] === m_pat[i]) n_pass++;
      else $error("FAIL %s[h%0d] pattern: got %b want %b", tag, hold_of(i), obs[i][7:5], m_pat[i]);
      n_chk++;
      assert (obs[i][4:3] === {m_run[i], m_done[i]}) n_pass++;
      else $error("FAIL %s[h%0d] busy/done: got %b want %b", tag, hold_of(i), obs[i][4:3], {m_run[i], m_done[i]});
      n_chk++;
      assert (obs[i][2:0] === m_step[i]) n_pass++;
      else $error("FAIL %s[h%0d] step: got %0d want %0d", tag, hold_of(i), obs[i][2:0], m_step[i]);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int c = 0; c < n; c++) tick(tag);
  endtask

  initial begin
    logic [2:0] pats [4];
    pats[0] = 3'b010; pats[1] = 3'b110; pats[2] = 3'b011; pats[3] = 3'b000;

    rst = 1'b1; start = 1'b0; loop = 1'b0; wr_en = 1'b0;
    num_steps = 3'd0; wr_addr = 3'd0; wr_data = 3'd0;
    ticks(2, "reset");
    rst = 1'b0;
    tick("idle");

    // load the directed table
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = pats[a];
      tick("load");
    end
    wr_en = 1'b0;

    // first pass; a start plus a write to entry 1 arrive mid-run
    num_steps = 3'd3; start = 1'b1;
    tick("pass_start");
    start = 1'b0;
    ticks(6, "pass");
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'b111;
    tick("midrun_req");
    start = 1'b0; wr_en = 1'b0;
    ticks(14, "pass_end");

    // replay shows the table unchanged, then reset during step 2
    start = 1'b1;
    tick("replay_start");
    start = 1'b0;
    ticks(9, "replay");
    rst = 1'b1;
    tick("midrun_rst");
    rst = 1'b0;
    tick("after_rst");

    // replay after reset plays the cleared table
    start = 1'b1;
    tick("cleared_start");
    start = 1'b0;
    ticks(20, "cleared");

    // three-step sequence (fast instance changes pattern every edge)
    for (int a = 0; a < 3; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 3'(3'd5 + 3'(a));
      tick("load3");
    end
    wr_en = 1'b0; num_steps = 3'd2; start = 1'b1;
    tick("three_start");
    start = 1'b0;
    ticks(14, "three");

    // loop request for two passes then dropped (ignored when looping is compiled out)
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = pats[a];
      tick("reload");
    end
    wr_en = 1'b0; num_steps = 3'd3; loop = 1'b1; start = 1'b1;
    tick("loop_start");
    start = 1'b0;
    ticks(36, "loop");
    loop = 1'b0;
    ticks(20, "loop_end");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom % 300) == 0;
      start     = ($urandom % 6) == 0;
      wr_en     = ($urandom % 3) == 0;
      wr_addr   = 3'($urandom);
      wr_data   = 3'($urandom);
      num_steps = 3'($urandom);
      loop      = ($urandom % 3) == 0;
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
